// File: rtl/param_digital_lock.sv
// Sequence-code lock: unlocks after N consecutive valid symbols match the code latched at reset; optional auto-relock via DLOCK_AUTORELOCK_EN.
// Latency: one edge from a sampled symbol to every registered output.
// Backpressure: none; symbols are consumed whenever x_valid=1 and dropped while in LOCKOUT.
module param_digital_lock #(
    parameter int W              = 3,
    parameter int N              = 3,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int OPEN_CYCLES    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [W-1:0]                  x,
    input  logic                          x_valid,
    input  logic [N*W-1:0]                code,
    output logic                          y,
    output logic [1:0]                    state,
    output logic [$clog2(N+1)-1:0]        progress,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);
    localparam int PW = $clog2(N + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ENTRY   = 2'b00,
        OPEN    = 2'b01,
        LOCKOUT = 2'b10
    } lock_state_t;

    lock_state_t       st;
    logic [N*W-1:0]    code_q;
    logic [LW-1:0]     lock_tmr;
    logic [W-1:0]      exp_sym;
    logic [FW-1:0]     fail_inc;

`ifdef DLOCK_AUTORELOCK_EN
    localparam int OW = $clog2(OPEN_CYCLES + 1);
    logic [OW-1:0]     open_tmr;
`endif

    // Symbol expected next, selected by how far the entry has progressed.
    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < N; i++) begin
            if (progress == PW'(i))
                exp_sym = code_q[i*W +: W];
        end
    end

    assign fail_inc = fail_cnt + FW'(1);
    assign state    = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q   <= code;
            st       <= ENTRY;
            y        <= 1'b0;
            progress <= '0;
            fail_cnt <= '0;
            lock_tmr <= '0;
`ifdef DLOCK_AUTORELOCK_EN
            open_tmr <= '0;
`endif
        end else begin
            case (st)
                ENTRY: begin
                    if (x_valid) begin
                        if (x == exp_sym) begin
                            if (progress == PW'(N - 1)) begin
                                st       <= OPEN;
                                y        <= 1'b1;
                                progress <= PW'(N);
                                fail_cnt <= '0;
`ifdef DLOCK_AUTORELOCK_EN
                                open_tmr <= OW'(OPEN_CYCLES - 1);
`endif
                            end else begin
                                progress <= progress + PW'(1);
                            end
                        end else if (progress != '0) begin
                            fail_cnt <= fail_inc;
                            if (fail_inc == FW'(MAX_FAIL)) begin
                                st       <= LOCKOUT;
                                progress <= '0;
                                lock_tmr <= LW'(LOCKOUT_CYCLES - 1);
                            end else begin
                                // A mismatching symbol may itself start a fresh attempt.
                                progress <= (x == code_q[W-1:0]) ? PW'(1) : '0;
                            end
                        end
                    end
                end
                OPEN: begin
`ifdef DLOCK_AUTORELOCK_EN
                    open_tmr <= open_tmr - OW'(1);
                    if (x_valid || open_tmr == '0) begin
`else
                    if (x_valid) begin
`endif
                        st       <= ENTRY;
                        y        <= 1'b0;
                        progress <= '0;
                    end
                end
                LOCKOUT: begin
                    if (lock_tmr == '0) begin
                        st       <= ENTRY;
                        fail_cnt <= '0;
                        progress <= '0;
                    end else begin
                        lock_tmr <= lock_tmr - LW'(1);
                    end
                end
                default: begin
                    st       <= ENTRY;
                    y        <= 1'b0;
                    progress <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_digital_lock.sv
// Directed table of {reset, code, symbol} -> {y, state, progress, fail_cnt} with hand-computed expectations.
module tb_param_digital_lock;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] x = 3'b000;
    logic       x_valid = 1'b0;
    logic [8:0] code = 9'b101_111_011;
    logic       y;
    logic [1:0] state;
    logic [1:0] progress;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [8:0] C1 = 9'b101_111_011;
    localparam logic [8:0] C2 = 9'b000_010_001;

    param_digital_lock dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .code(code),
        .y(y), .state(state), .progress(progress), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [8:0] cd;
        logic       xv;
        logic [2:0] sym;
        logic [6:0] exp; // {y, state, progress, fail_cnt}
        string      nm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [8:0] cd, input logic xv, input logic [2:0] sym,
                       input logic ey, input logic [1:0] es, input logic [1:0] ep, input logic [1:0] ef,
                       input string nm);
        vec_t v;
        v.rst = rst; v.cd = cd; v.xv = xv; v.sym = sym;
        v.exp = {ey, es, ep, ef}; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [6:0] exp);
        checks++;
        if ({y, state, progress, fail_cnt} !== exp) begin
            errors++;
            $display("FAIL %s: y/state/progress/fail_cnt got %b/%b/%b/%b expected %b/%b/%b/%b",
                     nm, y, state, progress, fail_cnt, exp[6], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic step(input logic rst, input logic [8:0] cd, input logic xv, input logic [2:0] sym);
        reset = rst; code = cd; x_valid = xv; x = sym;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unlock and relock
        add(1, C1, 0, 3'b000, 0, 2'd0, 2'd0, 2'd0, "reset");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd0, "unlock_s0");
        add(0, C1, 1, 3'b111, 0, 2'd0, 2'd2, 2'd0, "unlock_s1");
        add(0, C1, 1, 3'b101, 1, 2'd1, 2'd3, 2'd0, "unlock_s2");
        add(0, C1, 1, 3'b100, 0, 2'd0, 2'd0, 2'd0, "relock");
        // Restart on mismatch
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd0, "restart_s0");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd1, "restart_mismatch");
        add(0, C1, 1, 3'b111, 0, 2'd0, 2'd2, 2'd1, "restart_s1");
        add(0, C1, 1, 3'b101, 1, 2'd1, 2'd3, 2'd0, "restart_open");
        add(0, C1, 1, 3'b000, 0, 2'd0, 2'd0, 2'd0, "restart_relock");
        add(0, C1, 1, 3'b000, 0, 2'd0, 2'd0, 2'd0, "mismatch_at_zero");
        // Strobe gating
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd0, "gate_s0");
        add(0, C1, 0, 3'b101, 0, 2'd0, 2'd1, 2'd0, "gate_idle_a");
        add(0, C1, 0, 3'b111, 0, 2'd0, 2'd1, 2'd0, "gate_idle_b");
        add(0, C1, 1, 3'b111, 0, 2'd0, 2'd2, 2'd0, "gate_s1");
        add(0, C1, 0, 3'b000, 0, 2'd0, 2'd2, 2'd0, "gate_idle_c");
        add(0, C1, 1, 3'b101, 1, 2'd1, 2'd3, 2'd0, "gate_open");
        add(0, C1, 0, 3'b011, 1, 2'd1, 2'd3, 2'd0, "open_hold_invalid");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd0, 2'd0, "open_symbol_discarded");
        // Reset mid-operation with a new code
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd0, "mid_s0");
        add(0, C1, 1, 3'b111, 0, 2'd0, 2'd2, 2'd0, "mid_s1");
        add(1, C2, 1, 3'b101, 0, 2'd0, 2'd0, 2'd0, "mid_reset");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd0, 2'd0, "old_code_fails");
        add(0, C1, 1, 3'b001, 0, 2'd0, 2'd1, 2'd0, "new_s0");
        add(0, C1, 1, 3'b010, 0, 2'd0, 2'd2, 2'd0, "new_s1");
        add(0, C1, 1, 3'b000, 1, 2'd1, 2'd3, 2'd0, "new_open");
        add(1, C1, 0, 3'b000, 0, 2'd0, 2'd0, 2'd0, "reset_in_open");
        // Lockout
        for (int i = 0; i < 3; i++) begin
            add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'(i), "lock_good");
            if (i < 2) add(0, C1, 1, 3'b000, 0, 2'd0, 2'd0, 2'(i + 1), "lock_bad");
            else       add(0, C1, 1, 3'b000, 0, 2'd2, 2'd0, 2'd3, "lock_enter");
        end
        for (int i = 1; i < 16; i++) begin
            add(0, C1, 1, (i % 3 == 1) ? 3'b011 : (i % 3 == 2) ? 3'b111 : 3'b101,
                0, 2'd2, 2'd0, 2'd3, "lock_hold");
        end
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd0, 2'd0, "lock_exit");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd0, "post_s0");
        add(0, C1, 1, 3'b111, 0, 2'd0, 2'd2, 2'd0, "post_s1");
        add(0, C1, 1, 3'b101, 1, 2'd1, 2'd3, 2'd0, "post_open");
`ifdef DLOCK_AUTORELOCK_EN
        for (int i = 0; i < 7; i++) add(0, C1, 0, 3'b000, 1, 2'd1, 2'd3, 2'd0, "auto_open_hold");
        add(0, C1, 0, 3'b000, 0, 2'd0, 2'd0, 2'd0, "auto_relock");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd1, 2'd0, "auto2_s0");
        add(0, C1, 1, 3'b111, 0, 2'd0, 2'd2, 2'd0, "auto2_s1");
        add(0, C1, 1, 3'b101, 1, 2'd1, 2'd3, 2'd0, "auto2_open");
        for (int i = 0; i < 7; i++) add(0, C1, 0, 3'b000, 1, 2'd1, 2'd3, 2'd0, "auto2_hold");
        add(0, C1, 1, 3'b011, 0, 2'd0, 2'd0, 2'd0, "auto2_expire_with_valid");
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].cd, vecs[i].xv, vecs[i].sym);
            check(vecs[i].nm, vecs[i].exp);
        end

`ifndef DLOCK_AUTORELOCK_EN
        // Without auto-relock the lock stays open indefinitely.
        for (int i = 0; i < 100; i++) begin
            step(0, C1, 0, 3'(i));
            check("open_no_timeout", {1'b1, 2'd1, 2'd3, 2'd0});
        end
        step(1, C1, 1, 3'b011);
        check("reset_priority_open", 7'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_digital_lock.md
# param_digital_lock

Parametrised sequence-code lock: accepts a stream of W-bit symbols and asserts `y` when N consecutive valid symbols match a code latched at reset. Generalises the fixed 3-bit/3-symbol lock with a programmable code, a `x_valid` strobe, a failed-attempt counter with timed lockout, and an optional auto-relock timeout. Sits between the keypad/switch debouncer and the actuator driver.

## Interface

- `W`, 3: symbol width in bits.
- `N`, 3: code length in symbols (N ≥ 2).
- `MAX_FAIL`, 3: failed attempts before lockout (≥ 1).
- `LOCKOUT_CYCLES`, 16: lockout duration in clock cycles (≥ 1).
- `OPEN_CYCLES`, 8: auto-relock timeout in cycles (≥ 1; used only with `DLOCK_AUTORELOCK_EN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `x` in W: input symbol.
- `x_valid` in 1: `x` is consumed on a rising edge only when `x_valid`=1.
- `code` in N*W: secret code; symbol i in bits [i*W +: W]. Symbol 0 is entered first.
- `y` out 1: unlocked.
- `state` out 2: 00 ENTRY, 01 OPEN, 10 LOCKOUT. 11 is never driven.
- `progress` out clog2(N+1): number of symbols matched so far.
- `fail_cnt` out clog2(MAX_FAIL+1): failed attempts since the last unlock or lockout.

## Operation

- Reset: `code` is loaded into an internal register on every edge with `reset`=1. State becomes ENTRY. `y`=0, `progress`=0, `fail_cnt`=0, timers 0. `code` is ignored while `reset`=0.
- ENTRY, `x_valid`=1:
  - `x` == code[progress]: `progress`+1. If the new value is N, go to OPEN with `progress`=N.
  - Mismatch with `progress`=0: no failure is counted, and `progress` stays 0.
  - Mismatch with `progress`>0: `fail_cnt`+1. `progress` becomes 1 if `x` == code[0], else 0.
  - If the increment makes `fail_cnt` == MAX_FAIL, go to LOCKOUT instead. `progress`=0, and the lockout timer is loaded with LOCKOUT_CYCLES-1.
- ENTRY, `x_valid`=0: hold.
- OPEN: `y`=1 and `fail_cnt`=0. Entering OPEN clears `fail_cnt`.
  - Any `x_valid`=1: go to ENTRY with `progress`=0. The symbol is discarded and never matched against code[0].
- LOCKOUT: all `x_valid` is ignored. The timer decrements each cycle. On the edge where the timer is 0, go to ENTRY with `fail_cnt`=0 and `progress`=0.
- All outputs are registered and are direct functions of the state and counters.

## Timing

- A symbol sampled at edge k is reflected in the outputs immediately after edge k (latency 1 edge, no combinational path from input to output).
- Final correct symbol at edge k: `y`=1 and `state`=01 from edge k.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles with `state`=10, counted from the failing edge.
- OPEN timeout (macro on): `y` is high for exactly OPEN_CYCLES cycles, then ENTRY.
- Simultaneous `x_valid` and timeout expiry in OPEN: go to ENTRY, and the symbol is discarded.
- `reset` has priority over all events, including in OPEN and LOCKOUT.
- `x` is don't-care when `x_valid`=0.

## Configuration

- `DLOCK_AUTORELOCK_EN` defined:
  - Entering OPEN loads an open timer with OPEN_CYCLES-1.
  - The timer decrements each cycle.
  - On the edge where the timer is 0, go to ENTRY with `y`=0.
- `DLOCK_AUTORELOCK_EN` undefined:
  - No open timer is synthesised.
  - OPEN is held indefinitely until `x_valid`=1 or `reset`.

## Test plan

Defaults throughout: `code`=9'b101_111_011, so the entry order is 011, 111, 101.

- Unlock and relock:
  - Stimulus: reset, then valid symbols 011, 111, 101.
  - Response: `progress` 1, 2, 3; `y`=1 and `state`=01 after the third edge.
  - Then valid 100: `y`=0, `state`=00, `progress`=0.
- Restart on mismatch:
  - Stimulus: 011, 011, 111, 101.
  - Response: after the 2nd symbol `fail_cnt`=1 and `progress`=1. After the 4th `y`=1 and `fail_cnt`=0.
- Lockout:
  - Stimulus: (011, 000)×3.
  - Response: `state`=10 after the 6th symbol, with `fail_cnt`=3.
  - Valid 011/111/101 are ignored for 16 cycles.
  - Then `state`=00 and `fail_cnt`=0, and the correct code unlocks.
- Strobe gating:
  - Stimulus: the correct code with idle cycles between symbols. During the gaps `x` toggles with `x_valid`=0.
  - Response: unlocks on the last valid symbol, and `progress` is unchanged during gaps.
- Reset mid-operation:
  - Stimulus: after 011, 111, assert reset with `code`=9'b000_010_001.
  - Response: `progress`=0. The old code then fails, and 001, 010, 000 unlocks.
- Auto-relock:
  - Stimulus: unlock, then no input.
  - Response with macro defined: `y` falls after exactly 8 cycles.
  - Response with macro undefined: `y` stays 1 for at least 100 cycles.
